// File: rtl/bcd_seg_scan.sv
// Three-digit common-anode 7-segment scanner fed by a valid/ready BCD digit set.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module bcd_seg_scan #(
  parameter int REFRESH_DIV = 1000,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] d100,
  input  logic [3:0] d10,
  input  logic [3:0] d1,
  output logic [6:0] seg,
  output logic [2:0] an
);

  typedef enum logic [1:0] {
    S_D1   = 2'd0,
    S_D10  = 2'd1,
    S_D100 = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_s, frame_s, xfer_s;
  logic             pend_flag_r;
  logic [3:0]       pend_d100_r, pend_d10_r, pend_d1_r;
  logic [3:0]       disp_d100_r, disp_d10_r, disp_d1_r;
  logic [3:0]       digit_s;
  logic             blank_s;
  logic [6:0]       seg_nxt_s, seg_r;
  logic [2:0]       an_nxt_s, an_r;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign tick_s   = (cnt_r == CNT_W'(REFRESH_DIV - 1));
  assign frame_s  = tick_s && (state_r == S_D100);
  assign xfer_s   = in_valid && !pend_flag_r;
  assign in_ready = !pend_flag_r;
  assign seg      = seg_r;
  assign an       = an_r;

  // Prescaler: one tick every REFRESH_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Scan state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_D1;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan next-state: units -> tens -> hundreds, stepping on tick
  always_comb begin
    state_nxt_s = state_r;
    if (tick_s) begin
      case (state_r)
        S_D1:    state_nxt_s = S_D10;
        S_D10:   state_nxt_s = S_D100;
        S_D100:  state_nxt_s = S_D1;
        default: state_nxt_s = S_D1;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Pending capture and frame-boundary promotion; a transfer on the boundary
  // cycle sees pend_flag_r=0, so it waits for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_flag_r <= 1'b0;
      pend_d100_r <= 4'd0;
      pend_d10_r  <= 4'd0;
      pend_d1_r   <= 4'd0;
      disp_d100_r <= 4'd0;
      disp_d10_r  <= 4'd0;
      disp_d1_r   <= 4'd0;
    end else if (xfer_s) begin
      pend_flag_r <= 1'b1;
      pend_d100_r <= d100;
      pend_d10_r  <= d10;
      pend_d1_r   <= d1;
    end else if (frame_s && pend_flag_r) begin
      pend_flag_r <= 1'b0;
      disp_d100_r <= pend_d100_r;
      disp_d10_r  <= pend_d10_r;
      disp_d1_r   <= pend_d1_r;
    end
  end

  // Scan output decode for the slot currently selected
  always_comb begin
    digit_s   = disp_d1_r;
    blank_s   = 1'b0;
    an_nxt_s  = 3'b110;
    case (state_r)
      S_D1: begin
        digit_s  = disp_d1_r;
        an_nxt_s = 3'b110;
      end
      S_D10: begin
        digit_s  = disp_d10_r;
        an_nxt_s = 3'b101;
`ifdef LZ_BLANK_EN
        blank_s  = (disp_d100_r == 4'd0) && (disp_d10_r == 4'd0);
`else
        blank_s  = 1'b0;
`endif
      end
      S_D100: begin
        digit_s  = disp_d100_r;
        an_nxt_s = 3'b011;
`ifdef LZ_BLANK_EN
        blank_s  = (disp_d100_r == 4'd0);
`else
        blank_s  = 1'b0;
`endif
      end
      default: begin
        digit_s  = disp_d1_r;
        an_nxt_s = 3'b110;
      end
    endcase
    if (blank_s) begin
      seg_nxt_s = 7'b1111111;
    end else begin
      seg_nxt_s = seg_decode(digit_s);
    end
  end

  // Registered display drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= 7'b1111111;
      an_r  <= 3'b111;
    end else begin
      seg_r <= seg_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: cycle-count reference model plus
// hand-computed frame checks, REFRESH_DIV=4.
module tb_bcd_seg_scan;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] d100 = 4'd0, d10 = 4'd0, d1 = 4'd0;
  logic [6:0] seg;
  logic [2:0] an;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_seg_scan #(.REFRESH_DIV(R), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d100(d100), .d10(d10), .d1(d1), .seg(seg), .an(an)
  );

  // Reference model: position in the scan derived from edges since reset
  int         cyc;
  int         m_slot;
  int         m_pend;
  int         pend_d[3];
  int         disp_d[3];
  logic [6:0] exp_seg;
  logic [2:0] exp_an;

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] slot_seg(int slot);
    logic blank;
    blank = 1'b0;
`ifdef LZ_BLANK_EN
    if (slot == 2 && disp_d[2] == 0) blank = 1'b1;
    if (slot == 1 && disp_d[2] == 0 && disp_d[1] == 0) blank = 1'b1;
`endif
    return blank ? 7'b1111111 : glyph(disp_d[slot]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      m_pend = 0;
      for (int i = 0; i < 3; i++) begin
        pend_d[i] = 0;
        disp_d[i] = 0;
      end
      exp_seg = 7'b1111111;
      exp_an  = 3'b111;
    end else begin
      m_slot  = (cyc / R) % 3;
      exp_an  = 3'b111 & ~(3'b001 << m_slot);
      exp_seg = slot_seg(m_slot);
      if ((cyc % (3 * R)) == 3 * R - 1 && m_pend != 0) begin
        disp_d = pend_d;
        m_pend = 0;
      end else if (in_valid && m_pend == 0) begin
        pend_d[2] = int'(d100);
        pend_d[1] = int'(d10);
        pend_d[0] = int'(d1);
        m_pend = 1;
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act[6:0], exp[6:0], $time);
    end
  endtask

  // Every-cycle compare against the model
  always @(posedge clk) begin
    #2;
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("an", 32'(an), 32'(exp_an));
    chk("in_ready", 32'(in_ready), 32'(m_pend == 0));
  end

  // Literal expectation checked against both DUT and model
  task automatic pin(input string name, input logic [6:0] lseg, input logic [2:0] lan);
    chk({name, "_seg"}, 32'(seg), 32'(lseg));
    chk({name, "_an"}, 32'(an), 32'(lan));
    chk({name, "_model_seg"}, 32'(exp_seg), 32'(lseg));
    chk({name, "_model_an"}, 32'(exp_an), 32'(lan));
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ready();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_ready: in_ready stayed 0 for 40 cycles");
    end
  endtask

  task automatic load(input int a, input int b, input int c);
    wait_ready();
    in_valid = 1'b1;
    d100 = 4'(a);
    d10  = 4'(b);
    d1   = 4'(c);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_after_xfer", 32'(in_ready), 32'd0);
  endtask

  task automatic show(input string name, input logic [6:0] s100, input logic [6:0] s10,
                      input logic [6:0] s1);
    wait_ready();
    step();
    pin({name, "_u"}, s1, 3'b110);
    repeat (R) step();
    pin({name, "_t"}, s10, 3'b101);
    repeat (R) step();
    pin({name, "_h"}, s100, 3'b011);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    pin("in_reset", 7'b1111111, 3'b111);
    chk("ready_in_reset", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    pin("rel_u", 7'b1000000, 3'b110);
    repeat (R) step();
    pin("rel_t", 7'b1000000, 3'b101);
    repeat (R) step();
    pin("rel_h", 7'b1000000, 3'b011);

    load(1, 9, 3);
    in_valid = 1'b1;
    d100 = 4'd8;
    d10  = 4'd8;
    d1   = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    show("f193", 7'b1111001, 7'b0010000, 7'b0110000);

    load(0, 0, 7);
`ifdef LZ_BLANK_EN
    show("f007", 7'b1111111, 7'b1111111, 7'b1111000);
`else
    show("f007", 7'b1000000, 7'b1000000, 7'b1111000);
`endif

    load(0, 5, 0);
`ifdef LZ_BLANK_EN
    show("f050", 7'b1111111, 7'b0010010, 7'b1000000);
`else
    show("f050", 7'b1000000, 7'b0010010, 7'b1000000);
`endif

    load(1, 12, 0);
    show("f1c0", 7'b1111001, 7'b0111111, 7'b1000000);

    repeat (3) step();
    load(2, 5, 5);
    step();
    step();
    chk("pend_before_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    pin("mid_rst", 7'b1111111, 3'b111);
    chk("ready_mid_rst", 32'(in_ready), 32'd1);
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
    step();
    pin("post_u", 7'b1000000, 3'b110);
    repeat (R) step();
    pin("post_t", 7'b1000000, 3'b101);
    repeat (R) step();
    pin("post_h", 7'b1000000, 3'b011);
    repeat (6 * R) step();
    pin("post_late", 7'b1000000, exp_an);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the binary-to-BCD converter's d100/d10/d1 digit outputs.
- Drives a 3-digit, common-anode, time-multiplexed 7-segment display.
- Takes new digits through a valid/ready handshake and holds them in a pending register. The displayed value changes only at a scan-frame boundary, so the display never tears.

Parameters:
- REFRESH_DIV, 1000: clock cycles each digit is lit (must be ≥2).
- CNT_W, 10: prescaler counter width; must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  new digit set offered
- in_ready  output  1  block can accept a digit set
- d100  input  4  hundreds BCD digit
- d10  input  4  tens BCD digit
- d1  input  4  units BCD digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active low
- an  output  3  digit enables, active low: an[0]=units, an[1]=tens, an[2]=hundreds

Behaviour:
- Reset (async, active-high), while rst=1:
  - seg=7'b1111111, an=3'b111, in_ready=1.
  - Prescaler=0, scan state=S_D1, pending flag=0, pending and display digit registers=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 on the cycle the count equals REFRESH_DIV-1.
- Scan FSM, advancing only on tick: S_D1 -> S_D10 -> S_D100 -> S_D1.
  - Frame boundary = the tick taken in S_D100.
- Handshake:
  - in_ready = !pend_flag (combinational).
  - Transfer occurs when in_valid && in_ready at a clock edge: d100/d10/d1 are captured into the pending registers and pend_flag is set.
  - in_valid while in_ready=0 is ignored; inputs are not sampled.
- Display update:
  - At a frame boundary with pend_flag=1: pending is copied to the display registers and pend_flag is cleared. in_ready returns to 1 the next cycle.
  - Transfer and frame boundary in the same cycle: the boundary sees the old pend_flag=0, so no copy happens. The new data is shown after the following frame boundary.
- Outputs are registered: seg/an reflect the current scan state and display registers one cycle later.
  - First post-reset edge: an=3'b110, seg shows digit 0.
  - Exactly one an bit is low at all times outside reset.
- Decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Digit 10..15 = dash 0111111.
  - Blank = 1111111.
- Digit dwell is REFRESH_DIV cycles; one full frame is 3*REFRESH_DIV cycles.
- Worst-case latency from transfer to first display of the new value: just under 3*REFRESH_DIV + 1 cycles.
- Reset mid-operation: all state clears immediately (async). Pending data is discarded.

Optional Feature:
- Macro LZ_BLANK_EN, leading-zero blanking.
- Defined:
  - Hundreds slot shows blank if the display d100==0.
  - Tens slot shows blank if d100==0 && d10==0.
  - Units slot is never blanked.
  - an still scans all three digits.
  - An invalid digit (>9) is never treated as zero.
- Undefined: every slot always shows its decoded digit.

Test Plan (REFRESH_DIV=4):
1. Assert rst for 3 cycles -> seg=1111111, an=111, in_ready=1 during reset. One cycle after release: an=110, seg=1000000. an then steps 101, 011 every 4 cycles.
2. Pulse in_valid with d100=1, d10=9, d1=3 -> in_ready=0 the next cycle and stays 0 until after the frame boundary. The following frame shows an=110 seg=0110000, an=101 seg=0010000, an=011 seg=1111001.
3. While in_ready=0, drive in_valid with 8,8,8 -> ignored; the display shows 1,9,3 for the next frame.
4. Load 0,0,7 -> with LZ_BLANK_EN, the hundreds and tens slots show seg=1111111 while units shows 1111000. Without the macro, hundreds and tens show 1000000.
5. Load 0,5,0 (LZ_BLANK_EN) -> hundreds blank, tens 0010010, units 1000000. Load 1,12,0 -> tens slot shows dash 0111111.
6. Transfer 2,5,5, then assert rst mid-frame with pend_flag=1 -> immediate seg=1111111, an=111, in_ready=1. After release the display shows 0,0,0 and the pending value never appears.
